// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the NxN matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, FLUSH, DRAIN, DONE} state_t;

    localparam int DEF_N       = 3;
    localparam int DEF_MAC_LAT = 2;

    // $clog2 returns 0 for 1; every bus needs at least one bit.
    function automatic int clog2_min1(input int value);
        int w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int addr_width(input int n);
        return clog2_min1(2 * n * n);
    endfunction

    function automatic int res_width(input int n);
        return clog2_min1(n * n);
    endfunction

    function automatic int idx_width(input int n);
        return clog2_min1(n);
    endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Valid/address shift register that tracks MAC results in flight; the tail
// marks the cycle a finished C element leaves the MAC.
module mac_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [AW-1:0] push_addr,
    output logic          tail_valid,
    output logic [AW-1:0] tail_addr,
    output logic          pending
);

    logic [DEPTH-1:0]         valid_reg;
    logic [DEPTH-1:0]         valid_next;
    logic [DEPTH-1:0][AW-1:0] addr_reg;
    logic [DEPTH-1:0][AW-1:0] addr_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = push_valid;
                assign addr_next[gi]  = push_addr;
            end else begin : g_body
                assign valid_next[gi] = valid_reg[gi-1];
                assign addr_next[gi]  = addr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            addr_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            addr_reg  <= addr_next;
        end
    end

    assign tail_valid = valid_reg[DEPTH-1];
    assign tail_addr  = addr_reg[DEPTH-1];

    // Anything still ahead of the tail means the pipe is not empty after this edge.
    generate
        if (DEPTH > 1) begin : g_pending
            assign pending = |valid_reg[DEPTH-2:0];
        end else begin : g_no_pending
            assign pending = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/matmul_sequencer.sv
// Loop-counter sequencer for the NxN matmul datapath: loads A and B, issues
// N^3 MACs, waits out the MAC pipe, then streams C through the output mux.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int MAC_LAT = DEF_MAC_LAT,
    parameter int ADDR_W  = addr_width(N),
    parameter int RES_W   = res_width(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic              stall,
    output logic              ld_en,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [ADDR_W-1:0] rd_a_addr,
    output logic [ADDR_W-1:0] rd_b_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              res_we,
    output logic [RES_W-1:0]  res_addr,
    output logic [RES_W-1:0]  out_sel,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int                IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
    localparam logic [ADDR_W-1:0] LD_LAST  = ADDR_W'(2 * N * N - 1);
    localparam logic [ADDR_W-1:0] N_A      = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] NN_A     = ADDR_W'(N * N);
    localparam logic [RES_W-1:0]  N_R      = RES_W'(N);
    localparam logic [RES_W-1:0]  OUT_LAST = RES_W'(N * N - 1);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  ld_cnt_reg, ld_cnt_next;
    logic [IDX_W-1:0]   i_reg, i_next;
    logic [IDX_W-1:0]   j_reg, j_next;
    logic [IDX_W-1:0]   k_reg, k_next;
    logic [RES_W-1:0]   out_cnt_reg, out_cnt_next;

    logic [RES_W-1:0]   elem_idx;
    logic               push_valid;
    logic [RES_W-1:0]   push_addr;
    logic               pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ld_cnt_reg  <= '0;
            i_reg       <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            out_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ld_cnt_reg  <= ld_cnt_next;
            i_reg       <= i_next;
            j_reg       <= j_next;
            k_reg       <= k_next;
            out_cnt_reg <= out_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ld_cnt_next  = ld_cnt_reg;
        i_next       = i_reg;
        j_next       = j_reg;
        k_next       = k_reg;
        out_cnt_next = out_cnt_reg;
        ld_en        = 1'b0;
        ld_addr      = '0;
        rd_a_addr    = '0;
        rd_b_addr    = '0;
        mac_en       = 1'b0;
        mac_clr      = 1'b0;
        out_sel      = '0;
        out_valid    = 1'b0;
        done         = 1'b0;
        busy         = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = LOAD;
                    ld_cnt_next = '0;
                end
            end
            LOAD: begin
                ld_addr = ld_cnt_reg;
                if (in_valid) begin
                    ld_en       = 1'b1;
                    ld_cnt_next = ld_cnt_reg + ADDR_W'(1);
                    if (ld_cnt_reg == LD_LAST) begin
                        state_next = CALC;
                        i_next     = '0;
                        j_next     = '0;
                        k_next     = '0;
                    end
                end
            end
            CALC: begin
                // Addresses stay on the current (i,j,k) through a stall.
                rd_a_addr = ADDR_W'(i_reg) * N_A + ADDR_W'(k_reg);
                rd_b_addr = NN_A + ADDR_W'(k_reg) * N_A + ADDR_W'(j_reg);
                if (!stall) begin
                    mac_en  = 1'b1;
                    mac_clr = (k_reg == '0);
                    if (k_reg == IDX_LAST) begin
                        k_next = '0;
                        if (j_reg == IDX_LAST) begin
                            j_next = '0;
                            if (i_reg == IDX_LAST) begin
                                i_next     = '0;
                                state_next = FLUSH;
                            end else begin
                                i_next = i_reg + IDX_W'(1);
                            end
                        end else begin
                            j_next = j_reg + IDX_W'(1);
                        end
                    end else begin
                        k_next = k_reg + IDX_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!pending) begin
                    state_next   = DRAIN;
                    out_cnt_next = '0;
                end
            end
            DRAIN: begin
                out_valid    = 1'b1;
                out_sel      = out_cnt_reg;
                out_cnt_next = out_cnt_reg + RES_W'(1);
                if (out_cnt_reg == OUT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A C element is complete once its k==N-1 product has been issued.
    assign elem_idx   = RES_W'(i_reg) * N_R + RES_W'(j_reg);
    assign push_valid = mac_en & (k_reg == IDX_LAST);
    assign push_addr  = push_valid ? elem_idx : '0;

    mac_tag_pipe #(
        .DEPTH (MAC_LAT),
        .AW    (RES_W)
    ) u_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_addr  (push_addr),
        .tail_valid (res_we),
        .tail_addr  (res_addr),
        .pending    (pending)
    );

endmodule
